// File: rtl/scan_seq16_pkg.sv
// Shared definitions for the scan_seq16 channel sequencer: FSM states,
// default dwell time and channel count.
package scan_seq16_pkg;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  localparam int unsigned DWELL_DEFAULT = 4;
  localparam int unsigned NUM_CHAN      = 16;

endpackage

// File: rtl/next_chan16.sv
// Combinational channel search: next set index above cur (with found flag)
// and the lowest set index of a 16-bit mask.
module next_chan16
  import scan_seq16_pkg::*;
(
  input  logic [15:0] mask,
  input  logic [3:0]  cur,
  output logic [3:0]  nxt,
  output logic        found,
  output logic [3:0]  low
);

  // Both scans run from the top down so the last hit is the lowest qualifying index.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    low   = '0;
    for (int unsigned i = NUM_CHAN; i > 0; i--) begin
      if (mask[i-1]) begin
        low = 4'(i - 1);
        if ((i - 1) > 32'(cur)) begin
          nxt   = 4'(i - 1);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_seq16.sv
// Scan sequencer driving a 4-to-16 active-low decoder: walks the enabled
// channels of a latched mask, holding each for DWELL cycles.
module scan_seq16
  import scan_seq16_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic [15:0] mask,
  output logic [3:0]  sel,
  output logic        en,
  output logic        busy,
  output logic        done
);

  scan_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      mask_q, mask_n;
  logic             mode_q, mode_n;
  logic [3:0]       sel_n;
  logic             en_n, busy_n, done_n;

  logic [15:0] search_mask;
  logic [3:0]  nxt_idx, low_idx;
  logic        nxt_found;
  logic        expire;

  // In IDLE the search looks at the live mask so the first channel is ready at start.
  assign search_mask = (state == SCAN_IDLE) ? mask : mask_q;
  assign expire      = (cnt == CNT_W'(DWELL - 1));

  next_chan16 u_next (
    .mask  (search_mask),
    .cur   (sel),
    .nxt   (nxt_idx),
    .found (nxt_found),
    .low   (low_idx)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mask_n  = mask_q;
    mode_n  = mode_q;
    sel_n   = sel;
    en_n    = en;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      SCAN_IDLE: begin
        if (start && !stop && (mask != '0)) begin
          state_n = SCAN_RUN;
          mask_n  = mask;
          mode_n  = mode;
          sel_n   = low_idx;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      SCAN_RUN: begin
        if (stop) begin
          state_n = SCAN_IDLE;
          en_n    = 1'b0;
          busy_n  = 1'b0;
        end else if (expire) begin
          cnt_n = '0;
          if (nxt_found) begin
            sel_n = nxt_idx;
          end else if (mode_q) begin
            sel_n = low_idx;
          end else begin
            state_n = SCAN_IDLE;
            en_n    = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SCAN_IDLE;
      cnt    <= '0;
      mask_q <= '0;
      mode_q <= 1'b0;
      sel    <= '0;
      en     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mask_q <= mask_n;
      mode_q <= mode_n;
      sel    <= sel_n;
      en     <= en_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule
